// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file access arbiter.
// Holds the FSM state encoding and the requester identifiers.
package regfile_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: on a tie, the requester that was not granted last wins.
// sel is one-hot (bit 0 = A, bit 1 = B); valid is high when any request is present.
module rr_arbiter2
    import regfile_arb_pkg::*;
(
    input  logic       req_a,
    input  logic       req_b,
    input  req_t       last,
    output logic [1:0] sel,
    output logic       valid
);

    always_comb begin
        sel = 2'b00;
        if (req_a && req_b) begin
            sel = (last == REQ_A) ? 2'b10 : 2'b01;
        end else if (req_a) begin
            sel = 2'b01;
        end else if (req_b) begin
            sel = 2'b10;
        end
    end

    assign valid = req_a | req_b;

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin access controller in front of the single-port register file.
// Optional address bounds checking and the err port are enabled by REGFILE_ARB_BOUNDS_EN.
//
// state | meaning
// IDLE  | arbitrate pending requests; rf_we low, rf_addr/rf_data hold
// ISSUE | granted access drives the register file; read data captured at exit
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int n          = 8,
    parameter int addr_width = 5,
    parameter int regcount   = 10
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic                  wr_a,
    input  logic                  wr_b,
    input  logic [addr_width-1:0] addr_a,
    input  logic [addr_width-1:0] addr_b,
    input  logic [n-1:0]          wdata_a,
    input  logic [n-1:0]          wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic [n-1:0]          rdata_a,
    output logic [n-1:0]          rdata_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic [addr_width-1:0] rf_addr,
    output logic [n-1:0]          rf_data,
    output logic                  rf_we,
    input  logic [n-1:0]          rf_rd,
    output logic                  busy
`ifdef REGFILE_ARB_BOUNDS_EN
    ,
    output logic                  err
`endif
);

    state_t                state;
    state_t                state_nxt;
    req_t                  last_gnt;
    logic [1:0]            pick;
    logic                  pick_valid;
    logic                  accept;
    logic                  wr_sel;
    logic [addr_width-1:0] addr_sel;
    logic [n-1:0]          wdata_sel;
    logic                  oob;
    logic                  oob_q;
    logic                  rd_pend;

    rr_arbiter2 u_rr (
        .req_a (req_a),
        .req_b (req_b),
        .last  (last_gnt),
        .sel   (pick),
        .valid (pick_valid)
    );

    assign accept    = (state == IDLE) && pick_valid;
    assign wr_sel    = pick[1] ? wr_b    : wr_a;
    assign addr_sel  = pick[1] ? addr_b  : addr_a;
    assign wdata_sel = pick[1] ? wdata_b : wdata_a;

`ifdef REGFILE_ARB_BOUNDS_EN
    localparam logic [addr_width-1:0] last_legal = addr_width'(regcount - 1);
    assign oob = (addr_sel > last_legal);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= accept && oob;
        end
    end
`else
    assign oob = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == ISSUE);

    // Everything driven toward the register file or the requesters is registered;
    // pulses default low every cycle and are raised only by the event that owns them.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
            rf_addr  <= '0;
            rf_data  <= '0;
            rf_we    <= 1'b0;
            rd_pend  <= 1'b0;
            oob_q    <= 1'b0;
            last_gnt <= REQ_B;
        end else begin
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            rf_we    <= 1'b0;
            if (accept) begin
                gnt_a    <= pick[0];
                gnt_b    <= pick[1];
                rf_addr  <= addr_sel;
                rf_data  <= wdata_sel;
                rf_we    <= wr_sel && !oob;
                rd_pend  <= !wr_sel;
                oob_q    <= oob;
                last_gnt <= pick[1] ? REQ_B : REQ_A;
            end else if (state == ISSUE && rd_pend) begin
                rd_pend <= 1'b0;
                if (last_gnt == REQ_B) begin
                    rdata_b  <= oob_q ? '0 : rf_rd;
                    rvalid_b <= 1'b1;
                end else begin
                    rdata_a  <= oob_q ? '0 : rf_rd;
                    rvalid_a <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter with a behavioural register file attached.
// Read expectations come from a shadow copy of the register contents via per-requester queues.
module tb_regfile_arbiter;

    localparam int N  = 8;
    localparam int AW = 5;
    localparam int RC = 10;

    logic          clk_sys = 1'b0;
    logic          rst_n   = 1'b1;
    logic          req_a = 1'b0, req_b = 1'b0;
    logic          wr_a = 1'b0, wr_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [N-1:0]  wdata_a = '0, wdata_b = '0;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b, rf_we, busy;
    logic [N-1:0]  rdata_a, rdata_b, rf_data, rf_rd;
    logic [AW-1:0] rf_addr;
`ifdef REGFILE_ARB_BOUNDS_EN
    logic          err;
`endif

    logic [N-1:0]  rf_mem [0:31];
    logic [N-1:0]  shadow [0:31];
    logic [N-1:0]  qa[$];
    logic [N-1:0]  qb[$];
    bit            gnt_log[$];
    bit            rv_log[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int cnt_gnt_a = 0, cnt_gnt_b = 0, cnt_we = 0, cnt_rv_a = 0, cnt_rv_b = 0;
    int cnt_err = 0, both_gnt = 0, last_rv_cyc_a = -1;
    logic [AW-1:0] last_we_addr = '0;
    logic          busy_at_gnt = 1'b0;
    logic [N-1:0]  mon_exp_a, mon_exp_b;

    regfile_arbiter #(.n(N), .addr_width(AW), .regcount(RC)) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .req_a    (req_a),
        .req_b    (req_b),
        .wr_a     (wr_a),
        .wr_b     (wr_b),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .wdata_a  (wdata_a),
        .wdata_b  (wdata_b),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .rvalid_a (rvalid_a),
        .rvalid_b (rvalid_b),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .rf_we    (rf_we),
        .rf_rd    (rf_rd),
        .busy     (busy)
`ifdef REGFILE_ARB_BOUNDS_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Behavioural register file: combinational read, write on the rising edge.
    always @(posedge clk_sys) if (rf_we) rf_mem[rf_addr] <= rf_data;
    assign rf_rd = rf_mem[rf_addr];

    always @(negedge clk_sys) begin
        if (gnt_a) begin cnt_gnt_a++; gnt_log.push_back(1'b0); end
        if (gnt_b) begin cnt_gnt_b++; gnt_log.push_back(1'b1); end
        if (gnt_a && gnt_b) both_gnt++;
        if (rf_we) begin cnt_we++; last_we_addr = rf_addr; end
`ifdef REGFILE_ARB_BOUNDS_EN
        if (err) cnt_err++;
`endif
        if (rvalid_a) begin
            cnt_rv_a++;
            last_rv_cyc_a = cyc;
            rv_log.push_back(1'b0);
            n_checks++;
            if (qa.size() == 0) begin
                $display("FAIL rvalid_a_unexpected: got rdata_a=%h, required no response", rdata_a);
            end else begin
                mon_exp_a = qa.pop_front();
                if (rdata_a !== mon_exp_a)
                    $display("FAIL rdata_a: got %h, required %h", rdata_a, mon_exp_a);
                else n_pass++;
            end
        end
        if (rvalid_b) begin
            cnt_rv_b++;
            rv_log.push_back(1'b1);
            n_checks++;
            if (qb.size() == 0) begin
                $display("FAIL rvalid_b_unexpected: got rdata_b=%h, required no response", rdata_b);
            end else begin
                mon_exp_b = qb.pop_front();
                if (rdata_b !== mon_exp_b)
                    $display("FAIL rdata_b: got %h, required %h", rdata_b, mon_exp_b);
                else n_pass++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the grant, request dropped.
    task automatic do_access(input bit sel_b, input bit wr, input logic [AW-1:0] addr,
                             input logic [N-1:0] wdata, output int gcyc);
        bit seen;
        logic [N-1:0] e;
        if (!wr) begin
            e = shadow[addr];
`ifdef REGFILE_ARB_BOUNDS_EN
            if (int'(addr) >= RC) e = '0;
`endif
            if (sel_b) qb.push_back(e); else qa.push_back(e);
        end else begin
`ifdef REGFILE_ARB_BOUNDS_EN
            if (int'(addr) < RC) shadow[addr] = wdata;
`else
            shadow[addr] = wdata;
`endif
        end
        if (sel_b) begin req_b = 1'b1; wr_b = wr; addr_b = addr; wdata_b = wdata; end
        else       begin req_a = 1'b1; wr_a = wr; addr_a = addr; wdata_a = wdata; end
        seen = 1'b0;
        gcyc = -100;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_sys);
            if (sel_b ? gnt_b : gnt_a) begin
                seen = 1'b1;
                gcyc = cyc;
                busy_at_gnt = busy;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL grant_timeout: got no grant for %s, required grant", sel_b ? "B" : "A");
        else n_pass++;
        @(posedge clk_sys); #1;
        if (sel_b) req_b = 1'b0; else req_a = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk_sys); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt_a, gnt_b, rvalid_a, rvalid_b, rf_we, busy} !== 6'b0)
            $display("FAIL reset_ctrl: got %b, required 000000", {gnt_a, gnt_b, rvalid_a, rvalid_b, rf_we, busy});
        else n_pass++;
        n_checks++;
        if ({rdata_a, rdata_b, rf_data, rf_addr} !== '0)
            $display("FAIL reset_data: got %h, required 0", {rdata_a, rdata_b, rf_data, rf_addr});
        else n_pass++;
        repeat (2) @(posedge clk_sys);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int we0, ga0, rv0, t0, g;
        we0 = cnt_we; ga0 = cnt_gnt_a;
        t0 = cyc;
        do_access(1'b0, 1'b1, 5'd3, 8'h5A, g);
        n_checks++;
        if (g - t0 !== 1) $display("FAIL wr_grant_latency: got %0d, required 1", g - t0); else n_pass++;
        n_checks++;
        if (cnt_we - we0 !== 1) $display("FAIL rf_we_cycles: got %0d, required 1", cnt_we - we0); else n_pass++;
        n_checks++;
        if (last_we_addr !== 5'd3) $display("FAIL rf_we_addr: got %0d, required 3", last_we_addr); else n_pass++;
        n_checks++;
        if (cnt_gnt_a - ga0 !== 1) $display("FAIL gnt_a_width: got %0d, required 1", cnt_gnt_a - ga0); else n_pass++;
        n_checks++;
        if (busy_at_gnt !== 1'b1) $display("FAIL busy_issue: got %b, required 1", busy_at_gnt); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL busy_idle: got %b, required 0", busy); else n_pass++;
        rv0 = cnt_rv_a;
        t0 = cyc;
        do_access(1'b0, 1'b0, 5'd3, 8'h00, g);
        @(negedge clk_sys); #1;
        n_checks++;
        if (cnt_rv_a - rv0 !== 1) $display("FAIL rvalid_a_count: got %0d, required 1", cnt_rv_a - rv0); else n_pass++;
        n_checks++;
        if (last_rv_cyc_a - t0 !== 2) $display("FAIL read_latency: got %0d, required 2", last_rv_cyc_a - t0); else n_pass++;
        n_checks++;
        if (rdata_a !== 8'h5A) $display("FAIL rdata_a_hold: got %h, required 5a", rdata_a); else n_pass++;
    endtask

    task automatic test_fairness();
        bit exp_order[4];
        int ra0, rb0, bg0;
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        gnt_log.delete(); rv_log.delete();
        ra0 = cnt_rv_a; rb0 = cnt_rv_b; bg0 = both_gnt;
        repeat (2) begin qa.push_back(shadow[0]); qb.push_back(shadow[0]); end
        req_a = 1'b1; wr_a = 1'b0; addr_a = 5'd0;
        req_b = 1'b1; wr_b = 1'b0; addr_b = 5'd0;
        repeat (8) @(posedge clk_sys);
        #1 req_a = 1'b0; req_b = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        n_checks++;
        if (gnt_log.size() !== 4) $display("FAIL grant_count: got %0d, required 4", gnt_log.size()); else n_pass++;
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
            n_checks++;
            if (gnt_log[i] !== exp_order[i])
                $display("FAIL grant_order[%0d]: got %s, required %s", i, gnt_log[i] ? "B" : "A", exp_order[i] ? "B" : "A");
            else n_pass++;
        end
        for (int i = 0; i < 4 && i < rv_log.size(); i++) begin
            n_checks++;
            if (rv_log[i] !== exp_order[i])
                $display("FAIL rvalid_order[%0d]: got %s, required %s", i, rv_log[i] ? "B" : "A", exp_order[i] ? "B" : "A");
            else n_pass++;
        end
        n_checks++;
        if (both_gnt - bg0 !== 0) $display("FAIL gnt_overlap: got %0d, required 0", both_gnt - bg0); else n_pass++;
        n_checks++;
        if ((cnt_rv_a - ra0) + (cnt_rv_b - rb0) !== 4)
            $display("FAIL rvalid_total: got %0d, required 4", (cnt_rv_a - ra0) + (cnt_rv_b - rb0));
        else n_pass++;
    endtask

    task automatic test_raw_cross();
        int t0, g;
        do_access(1'b0, 1'b1, 5'd7, 8'hC3, g);
        t0 = cyc;
        do_access(1'b1, 1'b0, 5'd7, 8'h00, g);
        n_checks++;
        if (g - t0 !== 1) $display("FAIL b_grant_latency: got %0d, required 1", g - t0); else n_pass++;
        @(negedge clk_sys); #1;
        n_checks++;
        if (rdata_b !== 8'hC3) $display("FAIL rdata_b_raw: got %h, required c3", rdata_b); else n_pass++;
    endtask

    task automatic test_reset_in_issue();
        int g, rv0, rvb0;
        bit seen;
        do_access(1'b0, 1'b1, 5'd2, 8'h24, g);
        rv0 = cnt_rv_a; rvb0 = cnt_rv_b;
        req_a = 1'b1; wr_a = 1'b1; addr_a = 5'd2; wdata_a = 8'hFF;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_sys);
            if (gnt_a) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL abort_grant_timeout: got no grant, required grant"); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (rf_we !== 1'b0) $display("FAIL abort_rf_we: got %b, required 0", rf_we); else n_pass++;
        n_checks++;
        if ({gnt_a, busy} !== 2'b00) $display("FAIL abort_gnt_busy: got %b, required 00", {gnt_a, busy}); else n_pass++;
        req_a = 1'b0; wr_a = 1'b0;
        @(posedge clk_sys); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        n_checks++;
        if (rf_mem[2] !== 8'h24) $display("FAIL abort_reg2: got %h, required 24", rf_mem[2]); else n_pass++;
        n_checks++;
        if ((cnt_rv_a - rv0) + (cnt_rv_b - rvb0) !== 0)
            $display("FAIL abort_rvalid: got %0d, required 0", (cnt_rv_a - rv0) + (cnt_rv_b - rvb0));
        else n_pass++;
        do_access(1'b0, 1'b0, 5'd2, 8'h00, g);
        @(negedge clk_sys); #1;
    endtask

    task automatic test_b_back_to_back();
        int t0, g1, g2, g3;
        t0 = cyc;
        do_access(1'b1, 1'b1, 5'd5, 8'h77, g1);
        do_access(1'b1, 1'b0, 5'd5, 8'h00, g2);
        do_access(1'b1, 1'b0, 5'd1, 8'h00, g3);
        @(negedge clk_sys); #1;
        n_checks++;
        if (g1 - t0 !== 1) $display("FAIL b_first_latency: got %0d, required 1", g1 - t0); else n_pass++;
        n_checks++;
        if (g2 - g1 !== 2) $display("FAIL b_cadence_1: got %0d, required 2", g2 - g1); else n_pass++;
        n_checks++;
        if (g3 - g2 !== 2) $display("FAIL b_cadence_2: got %0d, required 2", g3 - g2); else n_pass++;
    endtask

`ifdef REGFILE_ARB_BOUNDS_EN
    task automatic test_bounds();
        int e0, w0, g;
        e0 = cnt_err; w0 = cnt_we;
        do_access(1'b0, 1'b1, 5'd12, 8'h11, g);
        do_access(1'b0, 1'b0, 5'd12, 8'h00, g);
        @(negedge clk_sys); #1;
        n_checks++;
        if (cnt_err - e0 !== 2) $display("FAIL err_pulses: got %0d, required 2", cnt_err - e0); else n_pass++;
        n_checks++;
        if (cnt_we - w0 !== 0) $display("FAIL oob_rf_we: got %0d, required 0", cnt_we - w0); else n_pass++;
        n_checks++;
        if (rdata_a !== 8'h00) $display("FAIL oob_rdata: got %h, required 00", rdata_a); else n_pass++;
    endtask
`endif

    task automatic test_final();
        for (int i = 0; i < RC; i++) begin
            n_checks++;
            if (rf_mem[i] !== shadow[i]) $display("FAIL reg_contents[%0d]: got %h, required %h", i, rf_mem[i], shadow[i]);
            else n_pass++;
        end
        n_checks++;
        if (qa.size() + qb.size() !== 0)
            $display("FAIL missing_responses: got %0d outstanding, required 0", qa.size() + qb.size());
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = 8'(i * 29 + 3);
            shadow[i] = 8'(i * 29 + 3);
        end
        test_reset();
        test_write_read();
        test_fairness();
        test_raw_cross();
        test_reset_in_issue();
        test_b_back_to_back();
`ifdef REGFILE_ARB_BOUNDS_EN
        test_bounds();
`endif
        repeat (3) @(posedge clk_sys);
        #1;
        test_final();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
